// File: rtl/freq_change_responder.sv
// freq_change_responder
// PHY/PLL-side agent for the memory-controller frequency-change handshake.
// Rising edges on start_freq_change_i and pll_freq_chng_done_i drive a small
// FSM (IDLE -> PREP -> WAIT_PLL -> RELOCK -> IDLE). The FSM models PHY
// preparation and PLL relock latency with a shared counter and returns
// registered one-cycle ready/done/error/timeout pulses.
module freq_change_responder #(
  parameter int FIDX_W      = 4,
  parameter int NB_FREQ     = 8,
  parameter int READY_DLY   = 6,
  parameter int LOCK_DLY    = 8,
  parameter int WDOG_CYCLES = 64
) (
  input  logic              pclk_i,
  input  logic              prst_ni,
  input  logic              start_freq_change_i,
  input  logic [FIDX_W-1:0] freq_index_i,
  input  logic              pll_freq_chng_done_i,
  output logic              freq_change_ready_o,
  output logic              freq_change_done_o,
  output logic              freq_change_error_o,
  output logic              watch_dog_timeout_o,
  output logic              busy_o,
  output logic [FIDX_W-1:0] cur_freq_idx_o
);

  localparam int CNT_W = 16;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREP     = 2'd1;
  localparam logic [1:0] ST_WAIT_PLL = 2'd2;
  localparam logic [1:0] ST_RELOCK   = 2'd3;

  localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(READY_DLY - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_DLY - 1);
  localparam logic [CNT_W-1:0] WDOG_LAST  = CNT_W'(WDOG_CYCLES - 1);
  localparam logic [FIDX_W:0]  NB_FREQ_X  = (FIDX_W+1)'(NB_FREQ);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FIDX_W-1:0] target_q, target_d;
  logic [FIDX_W-1:0] cur_q, cur_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              wdog_q, wdog_d;
  logic              busy_q, busy_d;

  // Edge detection. arm_q stays low for the first clock after reset release
  // so that an input already high at release is not mistaken for an edge.
  logic start_dly_q;
  logic pll_dly_q;
  logic arm_q;
  logic start_ev;
  logic pll_ev;
  logic idx_illegal;

  assign start_ev    = arm_q & start_freq_change_i & ~start_dly_q;
  assign pll_ev      = arm_q & pll_freq_chng_done_i & ~pll_dly_q;
  assign idx_illegal = ({1'b0, freq_index_i} >= NB_FREQ_X);

  // Next-state logic: FSM transitions, latency counter and pulse generation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    cur_d    = cur_q;
    ready_d  = 1'b0;
    done_d   = 1'b0;
    error_d  = 1'b0;
    wdog_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ev) begin
          if (idx_illegal) begin
            error_d = 1'b1;
          end else begin
            target_d = freq_index_i;
            cnt_d    = '0;
            state_d  = ST_PREP;
          end
        end
      end
      ST_PREP: begin
        if (cnt_q == READY_LAST) begin
          ready_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT_PLL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_PLL: begin
        // A PLL-done edge on the terminal count still counts as success.
        if (pll_ev) begin
          cnt_d   = '0;
          state_d = ST_RELOCK;
        end else if (cnt_q == WDOG_LAST) begin
          wdog_d  = 1'b1;
          error_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin  // ST_RELOCK
        if (cnt_q == LOCK_LAST) begin
          cur_d   = target_q;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, counters, edge-detect copies and registered outputs.
  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      target_q    <= '0;
      cur_q       <= '0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      wdog_q      <= 1'b0;
      busy_q      <= 1'b0;
      start_dly_q <= 1'b0;
      pll_dly_q   <= 1'b0;
      arm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      cur_q       <= cur_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      error_q     <= error_d;
      wdog_q      <= wdog_d;
      busy_q      <= busy_d;
      start_dly_q <= start_freq_change_i;
      pll_dly_q   <= pll_freq_chng_done_i;
      arm_q       <= 1'b1;
    end
  end

  assign freq_change_ready_o = ready_q;
  assign freq_change_done_o  = done_q;
  assign freq_change_error_o = error_q;
  assign watch_dog_timeout_o = wdog_q;
  assign busy_o              = busy_q;
  assign cur_freq_idx_o      = cur_q;

endmodule

// File: tb/tb_freq_change_responder.sv
// Testbench for freq_change_responder: a hand-written vector table, directed
// multi-cycle scenarios, then random stimulus checked against a timestamp
// based reference model (events are scheduled by absolute cycle number).
module tb_freq_change_responder;

  localparam int FIDX_W  = 4;
  localparam int NB_FREQ = 8;
  localparam int RDY     = 6;
  localparam int LCK     = 8;
  localparam int WDOG    = 64;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [3:0]  idx_i;
  logic        pll_i;
  logic        ready_o, done_o, err_o, wd_o, busy_o;
  logic [3:0]  cur_o;

  int n_cmp = 0;
  int n_bad = 0;

  freq_change_responder #(
    .FIDX_W(FIDX_W), .NB_FREQ(NB_FREQ), .READY_DLY(RDY),
    .LOCK_DLY(LCK), .WDOG_CYCLES(WDOG)
  ) dut (
    .pclk_i(clk),
    .prst_ni(rst_n),
    .start_freq_change_i(start_i),
    .freq_index_i(idx_i),
    .pll_freq_chng_done_i(pll_i),
    .freq_change_ready_o(ready_o),
    .freq_change_done_o(done_o),
    .freq_change_error_o(err_o),
    .watch_dog_timeout_o(wd_o),
    .busy_o(busy_o),
    .cur_freq_idx_o(cur_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A transaction is described by its accept cycle and (later) its PLL-done
  // cycle; every output pulse is a fixed offset from one of those.
  int   s_cnt = 0;        // absolute step number
  bit   m_busy;
  int   m_acc;
  int   m_pll;
  logic [3:0] m_tgt, m_cur;
  bit   m_prev_s, m_prev_p;
  int   m_since;
  int   last_ready = -1, last_done = -1, last_wd = -1;

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_pll = -1; m_tgt = 0; m_cur = 0;
    m_prev_s = 0; m_prev_p = 0; m_since = 0;
  endtask

  task automatic model_step(input bit s, input logic [3:0] idx, input bit p,
                            output logic [8:0] exp);
    bit es, ep, r, d, er, wd;
    int rdy_t;
    es = (m_since >= 1) && s && !m_prev_s;
    ep = (m_since >= 1) && p && !m_prev_p;
    r = 0; d = 0; er = 0; wd = 0;
    if (!m_busy) begin
      if (es) begin
        if (int'(idx) >= NB_FREQ) er = 1;
        else begin
          m_busy = 1; m_acc = s_cnt; m_pll = -1; m_tgt = idx;
        end
      end
    end else begin
      rdy_t = m_acc + RDY;
      if (s_cnt == rdy_t) r = 1;
      if (m_pll < 0) begin
        if (s_cnt > rdy_t && ep) m_pll = s_cnt;
        else if (s_cnt == rdy_t + WDOG) begin
          wd = 1; er = 1; m_busy = 0;
        end
      end else if (s_cnt == m_pll + LCK) begin
        d = 1; m_cur = m_tgt; m_busy = 0;
      end
    end
    m_prev_s = s; m_prev_p = p; m_since++;
    exp = {r, d, er, wd, m_busy, m_cur};
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @step %0d: got %0d, required %0d", name, s_cnt, act, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {ready_o, done_o, err_o, wd_o, busy_o, cur_o};
  endfunction

  // One clock: drive inputs, advance model, sample #1 after the edge, compare.
  task automatic step(input bit s, input logic [3:0] idx, input bit p);
    logic [8:0] exp, act;
    start_i = s; idx_i = idx; pll_i = p;
    model_step(s, idx, p, exp);
    @(posedge clk); #1;
    act = outs();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL model @step %0d: got rdy/done/err/wd/busy/cur=%b, required %b",
               s_cnt, act, exp);
    end
    $display("step %0d in s=%0d idx=%0d p=%0d out=%b", s_cnt, s, idx, p, act);
    if (ready_o) last_ready = s_cnt;
    if (done_o)  last_done  = s_cnt;
    if (wd_o)    last_wd    = s_cnt;
    s_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'd0, 0);
  endtask

  // Assert reset away from the clock edge, check the async clear, release.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    start_i = 0; pll_i = 0; idx_i = 0;
    #1 check("async_reset_outputs", int'(outs()), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  typedef struct {
    bit         s;
    logic [3:0] idx;
    bit         p;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[6];
  int   n0, pm, wd_before;

  initial begin
    rst_n = 1'b0; start_i = 0; idx_i = 0; pll_i = 0;
    model_reset();

    // Vector table: illegal indices and a PLL-done edge while idle.
    tbl[0] = '{0, 4'd0,  0, 9'b0_0_0_0_0_0000};
    tbl[1] = '{1, 4'd9,  0, 9'b0_0_1_0_0_0000};
    tbl[2] = '{1, 4'd9,  0, 9'b0_0_0_0_0_0000};
    tbl[3] = '{0, 4'd0,  1, 9'b0_0_0_0_0_0000};
    tbl[4] = '{1, 4'd15, 0, 9'b0_0_1_0_0_0000};
    tbl[5] = '{0, 4'd0,  0, 9'b0_0_0_0_0_0000};

    #3;
    check("reset_outputs", int'(outs()), 0);
    @(negedge clk) rst_n = 1'b1;

    idle(2);
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].s, tbl[i].idx, tbl[i].p);
      check($sformatf("table[%0d]", i), int'(outs()), int'(tbl[i].exp));
    end

    // Watchdog: valid start, PLL-done never arrives.
    n0 = s_cnt;
    step(1, 4'd3, 0);
    idle(RDY + WDOG + 4);
    check("wdog_ready_time", last_ready, n0 + RDY);
    check("wdog_timeout_time", last_wd, n0 + RDY + WDOG);
    check("wdog_cur_idx", int'(cur_o), 0);
    check("wdog_busy", int'(busy_o), 0);

    // Nominal, with a second start during PREP that must be ignored.
    n0 = s_cnt;
    step(1, 4'd5, 0);
    step(0, 4'd0, 0);
    step(1, 4'd2, 0);
    while (s_cnt <= n0 + RDY + 9) step(0, 4'd0, 0);
    check("nominal_ready_time", last_ready, n0 + RDY);
    pm = s_cnt;
    step(0, 4'd0, 1);
    idle(LCK + 3);
    check("nominal_done_time", last_done, pm + LCK);
    check("nominal_cur_idx", int'(cur_o), 5);
    check("nominal_busy", int'(busy_o), 0);

    // Watchdog race: PLL-done edge on the terminal watchdog count.
    wd_before = last_wd;
    n0 = s_cnt;
    step(1, 4'd3, 0);
    while (s_cnt < n0 + RDY + WDOG) step(0, 4'd0, 0);
    pm = s_cnt;
    step(0, 4'd0, 1);
    while (s_cnt <= pm + LCK) step(0, 4'd0, 0);
    check("race_no_timeout", last_wd, wd_before);
    check("race_done_time", last_done, pm + LCK);
    check("race_cur_idx", int'(cur_o), 3);

    // Back-to-back start in the first idle cycle, then reset mid-RELOCK.
    n0 = s_cnt;
    step(1, 4'd7, 0);
    check("b2b_accepted_busy", int'(busy_o), 1);
    while (s_cnt <= n0 + RDY) step(0, 4'd0, 0);
    step(0, 4'd0, 1);
    idle(3);
    do_reset();
    check("post_reset_cur_idx", int'(cur_o), 0);

    // Start held high across reset release must not start a transaction.
    step(1, 4'd2, 0);
    step(1, 4'd2, 0);
    check("held_start_no_busy", int'(busy_o), 0);
    step(0, 4'd0, 0);
    n0 = s_cnt;
    step(1, 4'd2, 0);
    while (s_cnt <= n0 + RDY + 2) step(0, 4'd0, 0);
    step(0, 4'd0, 1);
    idle(LCK + 2);
    check("fresh_after_reset_cur_idx", int'(cur_o), 2);

    // Random stimulus against the reference model.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 5) == 0, 4'($urandom_range(0, 9)),
           $urandom_range(0, 15) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
